// File: rtl/sr_seq_pkg.sv
// sr_seq_pkg
//   Shared definitions for the SR command sequencer:
//     state_e  - sequencer FSM states (IDLE / DRIVE / GAP)
//     OP_SET   - queued op value that drives s
//     OP_RST   - queued op value that drives r
//     CNT_W    - width of the pulse-length down-counter
package sr_seq_pkg;

    localparam int   CNT_W  = 4;
    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/sr_cmd_fifo.sv
// sr_cmd_fifo
//   1-bit wide command FIFO, DEPTH entries (power of 2, >= 2).
//   Pointers carry one extra wrap bit so full and empty are distinct.
//   Ports:
//     clk   - clock, rising edge
//     clear - synchronous active-high reset (empties the FIFO)
//     push  - write din this edge (ignored when full)
//     pop   - drop the head entry this edge (ignored when empty)
//     din   - data to write
//     dout  - current head entry
//     full  - no free entry
//     empty - no stored entry
module sr_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    // Same index bits, different wrap bit: writer is a full lap ahead.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sr_cmd_seq.sv
// sr_cmd_seq
//   Queues SET/RESET requests and replays each one as a PULSE_LEN-cycle
//   registered pulse on s (SET) or r (RESET) toward a downstream SR flop,
//   while tracking the q that flop should hold (q_model).
//   Optional build macro SR_SEQ_GAP_EN: inserts one idle (s=r=0) cycle
//   after every pulse. Undefined: pulses may run back-to-back.
//   Handshake: a request is accepted on an edge where exactly one of
//   set_req/rst_req is high and req_ready (FIFO not full) is high; there is
//   no same-cycle pop bypass. Both high is a collision and is never queued.
//   Ports:
//     clk       - clock, rising edge
//     clear     - synchronous active-high reset, beats all requests
//     set_req   - enqueue a SET this cycle
//     rst_req   - enqueue a RESET this cycle
//     req_ready - FIFO not full
//     s, r      - registered drives to the downstream SR flop
//     busy      - FSM not IDLE or FIFO non-empty
//     q_model   - expected downstream q after the last completed command
//     overflow  - sticky: a request was dropped on a full FIFO
//     collide   - sticky: set_req and rst_req were high together
//     state_dbg - current FSM state (sr_seq_pkg::state_e encoding)
module sr_cmd_seq
    import sr_seq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       set_req,
    input  logic       rst_req,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       q_model,
    output logic       overflow,
    output logic       collide,
    output logic [1:0] state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             qm_q, qm_d;
    logic             ovf_q, ovf_d;
    logic             col_q, col_d;

    logic fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;
    logic one_req, both_req, start;

    sr_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (set_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign one_req   = set_req ^ rst_req;
    assign both_req  = set_req & rst_req;
    // set_req doubles as the op bit because OP_SET is 1 and OP_RST is 0.
    assign fifo_push = one_req & ~fifo_full;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        s_d      = s_q;
        r_d      = r_q;
        qm_d     = qm_q;
        ovf_d    = ovf_q | (one_req & fifo_full);
        col_d    = col_q | both_req;
        start    = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
                start   = !fifo_empty;
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    qm_d = op_q;
                    s_d  = 1'b0;
                    r_d  = 1'b0;
`ifdef SR_SEQ_GAP_EN
                    state_d = GAP;
`else
                    // Chain straight into the next op so the lines switch
                    // on one edge: s/r are both recomputed from the new op.
                    state_d = IDLE;
                    start   = !fifo_empty;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase

        // Load the head op; s_d/r_d are complements so they never both set.
        if (start) begin
            state_d = DRIVE;
            op_d    = fifo_dout;
            cnt_d   = CNT_W'(PULSE_LEN);
            s_d     = (fifo_dout == OP_SET);
            r_d     = (fifo_dout == OP_RST);
        end
        fifo_pop = start;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RST;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            qm_q    <= 1'b0;
            ovf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s_q     <= s_d;
            r_q     <= r_d;
            qm_q    <= qm_d;
            ovf_q   <= ovf_d;
            col_q   <= col_d;
        end
    end

    assign req_ready = ~fifo_full;
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign q_model   = qm_q;
    assign overflow  = ovf_q;
    assign collide   = col_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_cmd_seq.sv
// tb_sr_cmd_seq
//   Bench for sr_cmd_seq (DEPTH=4, PULSE_LEN=2). Cycle tables for the
//   basic latency / back-to-back / collide cases, hand sequences for fill
//   and clear-in-flight, then a long random run. A negedge monitor slices
//   s/r activity into PULSE_LEN-cycle pulses, pops the expected op queue
//   for each one, and tracks a behavioural SR flop against q_model.
module tb_sr_cmd_seq;
    import sr_seq_pkg::*;

    localparam int DEPTH     = 4;
    localparam int PULSE_LEN = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       set_req = 1'b0;
    logic       rst_req = 1'b0;
    logic       req_ready, s, r, busy, q_model, overflow, collide;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    sr_cmd_seq #(
        .DEPTH     (DEPTH),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .set_req   (set_req),
        .rst_req   (rst_req),
        .req_ready (req_ready),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .q_model   (q_model),
        .overflow  (overflow),
        .collide   (collide),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int         tests     = 0;
    int         fails     = 0;
    int         pulse_cnt = 0;
    int         run_cnt   = 0;
    logic       run_line  = 1'b0;
    logic       sr_model  = 1'b0;
    bit         mon_en    = 1'b0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic       set_in;
        logic       rst_in;
        logic [6:0] exp;   // {req_ready, s, r, q_model, busy, overflow, collide}
    } vec_t;
    vec_t vecs[$];

    // ---------------- driver tasks ----------------
    task automatic drive_now(input logic st, input logic rs, input logic clr);
        if (!clr && (st ^ rs) && req_ready)
            exp_q.push_back(st ? OP_SET : OP_RST);
        set_req = st;
        rst_req = rs;
        clear   = clr;
    endtask

    task automatic tick(input logic st, input logic rs, input logic clr);
        @(negedge clk);
        #1;
        drive_now(st, rs, clr);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check1("wait_idle_busy", busy, 1'b0);
    endtask

    task automatic add_vec(input logic st, input logic rs, input logic [6:0] e);
        vec_t v;
        v.set_in = st;
        v.rst_in = rs;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (s === 1'b1 && r === 1'b1) begin
                fails++;
                $display("FAIL s_r_exclusive: got s=%b r=%b expected not both 1", s, r);
            end
            if (clear) begin
                exp_q.delete();
                run_cnt  = 0;
                sr_model = 1'b0;
                tests++;
                if (q_model !== 1'b0 || s !== 1'b0 || r !== 1'b0) begin
                    fails++;
                    $display("FAIL after_clear: got q_model=%b s=%b r=%b expected 0 0 0",
                             q_model, s, r);
                end
            end else begin
                if (s === 1'b0 && r === 1'b0) begin
                    tests++;
                    if (q_model !== sr_model) begin
                        fails++;
                        $display("FAIL q_model_vs_sr: got %b expected %b", q_model, sr_model);
                    end
                end
                if (s === 1'b1 || r === 1'b1) begin
                    if (run_cnt == 0 || s !== run_line || run_cnt == PULSE_LEN) begin
                        if (run_cnt != 0 && run_cnt != PULSE_LEN) begin
                            tests++;
                            fails++;
                            $display("FAIL pulse_len: got %0d expected %0d", run_cnt, PULSE_LEN);
                        end
                        pulse_cnt++;
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL pulse_op: got op %b expected no pulse", s);
                        end else begin
                            logic [0:0] e;
                            e = exp_q.pop_front();
                            if (e !== s) begin
                                fails++;
                                $display("FAIL pulse_op: got %b expected %b", s, e);
                            end
                        end
                        run_cnt  = 1;
                        run_line = s;
                    end else begin
                        run_cnt++;
                    end
                end else begin
                    if (run_cnt != 0) begin
                        tests++;
                        if (run_cnt != PULSE_LEN) begin
                            fails++;
                            $display("FAIL pulse_len: got %0d expected %0d", run_cnt, PULSE_LEN);
                        end
                    end
                    run_cnt = 0;
                end
                if (s === 1'b1)      sr_model = 1'b1;
                else if (r === 1'b1) sr_model = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] act;
        logic [7:0] exp_rdy;
        int         snap;
        logic       st, rs, clr;

        // cycle table: SET latency, SET then RESET back-to-back, collide
        add_vec(0, 0, 7'b1000000);
        add_vec(1, 0, 7'b1000000);
        add_vec(0, 0, 7'b1000100);
        add_vec(0, 0, 7'b1100100);
        add_vec(0, 0, 7'b1100100);
        add_vec(1, 0, 7'b1001000);
        add_vec(0, 1, 7'b1001100);
        add_vec(0, 0, 7'b1101100);
        add_vec(0, 0, 7'b1101100);
`ifdef SR_SEQ_GAP_EN
        add_vec(0, 0, 7'b1001100);
        add_vec(0, 0, 7'b1011100);
        add_vec(0, 0, 7'b1011100);
        add_vec(0, 0, 7'b1000000);
`else
        add_vec(0, 0, 7'b1011100);
        add_vec(0, 0, 7'b1011100);
        add_vec(0, 0, 7'b1000000);
`endif
        add_vec(1, 1, 7'b1000000);
        add_vec(0, 0, 7'b1000001);
        add_vec(0, 0, 7'b1000001);
        add_vec(0, 0, 7'b1000001);

        repeat (3) tick(0, 0, 1);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            act = {req_ready, s, r, q_model, busy, overflow, collide};
            tests++;
            if (act !== vecs[i].exp) begin
                fails++;
                $display("FAIL vec[%0d]: got rdy,s,r,qm,busy,ovf,col=%b expected %b",
                         i, act, vecs[i].exp);
            end
            #1;
            drive_now(vecs[i].set_in, vecs[i].rst_in, 1'b0);
        end

        // fill: eight SETs in a row, only the last meets a full FIFO
        repeat (2) tick(0, 0, 1);
        snap    = pulse_cnt;
        exp_rdy = 8'b0111_1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1($sformatf("fill_req_ready[%0d]", i), req_ready, exp_rdy[i]);
            #1;
            drive_now(1, 0, 0);
        end
        @(negedge clk);
        check1("fill_overflow", overflow, 1'b1);
        check1("fill_ready_after_pop", req_ready, 1'b1);
        #1;
        drive_now(0, 0, 0);
        wait_idle(100);
        repeat (2) @(negedge clk);
        tests++;
        if (pulse_cnt - snap != 7) begin
            fails++;
            $display("FAIL fill_pulses: got %0d expected 7", pulse_cnt - snap);
        end
        check1("overflow_sticky", overflow, 1'b1);
        check1("fill_q_model", q_model, 1'b1);

        // clear during the first DRIVE cycle of a RESET with two ops queued
        repeat (2) tick(0, 0, 1);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(1, 0, 0);
        tick(0, 1, 0);
        @(negedge clk);
        check1("pre_clear_r", r, 1'b1);
        check1("pre_clear_q_model", q_model, 1'b1);
        check1("pre_clear_busy", busy, 1'b1);
        #1;
        drive_now(1, 0, 1);
        @(negedge clk);
        check1("post_clear_s", s, 1'b0);
        check1("post_clear_r", r, 1'b0);
        check1("post_clear_busy", busy, 1'b0);
        check1("post_clear_q_model", q_model, 1'b0);
        check1("post_clear_ready", req_ready, 1'b1);
        check1("post_clear_overflow", overflow, 1'b0);
        #1;
        drive_now(0, 0, 0);
        snap = pulse_cnt;
        repeat (6) @(negedge clk);
        tests++;
        if (pulse_cnt != snap) begin
            fails++;
            $display("FAIL post_clear_pulses: got %0d expected 0", pulse_cnt - snap);
        end
        check1("post_clear_busy_late", busy, 1'b0);

        // random traffic
        for (int c = 0; c < 9000; c++) begin
            clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) begin
                st = 1'b1;
                rs = 1'b1;
            end else begin
                st = ($urandom_range(0, 99) < 25);
                rs = !st && ($urandom_range(0, 99) < 25);
            end
            tick(st, rs, clr);
        end
        tick(0, 0, 0);
        wait_idle(200);
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
